// File: rtl/hazard_scoreboard.sv
// Hazard/bypass controller: age-shift pipe of in-flight writers plus a busy scoreboard for
// variable-latency ops. Produces decode stalls, execute bubbles and bypass selects.
module hazard_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = 3,
  parameter int unsigned LW   = 2,
  parameter int unsigned SW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_d,
  input  logic [AW-1:0]   rs2_d,
  input  logic            use1_d,
  input  logic            use2_d,
  input  logic            iss_valid,
  input  logic            iss_we,
  input  logic [AW-1:0]   iss_rd,
  input  logic [LW-1:0]   iss_lat,
  input  logic            iss_long,
  input  logic            flush_d,
  input  logic            lu_ready,
  input  logic            lu_done,
  input  logic [AW-1:0]   lu_rd,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_e,
  output logic [SW-1:0]   fwd1_d,
  output logic [SW-1:0]   fwd2_d,
  output logic [NREG-1:0] sb_busy,
  output logic            sb_err
);

  logic            r_v   [1:NFWD];
  logic            r_we  [1:NFWD];
  logic [AW-1:0]   r_rd  [1:NFWD];
  logic [LW-1:0]   r_lat [1:NFWD];
  logic [NREG-1:0] r_busy;
  logic            r_err;

  logic [AW-1:0]   w_rs  [2];
  logic            w_use [2];
  logic            w_hz  [2];
  logic [SW-1:0]   w_fwd [2];
  logic            w_struct;
  logic            w_stall;
  logic            w_iss;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_err_nxt;

  assign w_rs[0]  = rs1_d;
  assign w_rs[1]  = rs2_d;
  assign w_use[0] = use1_d;
  assign w_use[1] = use2_d;

  // Youngest matching writer wins; a match that is not yet bypassable is a RAW stall.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      logic found;
      logic [LW-1:0] lat_eff;
      found    = 1'b0;
      lat_eff  = '0;
      w_hz[s]  = 1'b0;
      w_fwd[s] = '0;
      for (int k = 1; k <= int'(NFWD); k++) begin
        lat_eff = (r_lat[k] == '0) ? LW'(1) : r_lat[k];
        if (!found && r_v[k] && r_we[k] && (r_rd[k] == w_rs[s])) begin
          found = 1'b1;
          if (k >= int'(lat_eff)) w_fwd[s] = SW'(k);
          else                    w_hz[s]  = 1'b1;
        end
      end
      if (!found && r_busy[w_rs[s]]) w_hz[s] = 1'b1;
      if (!w_use[s] || (w_rs[s] == '0)) begin
        w_hz[s]  = 1'b0;
        w_fwd[s] = '0;
      end
    end
  end

  assign w_struct = (iss_long && !lu_ready) ||
                    (iss_we && (iss_rd != '0) && r_busy[iss_rd]);
  assign w_stall  = iss_valid && !flush_d && (w_hz[0] || w_hz[1] || w_struct);
  assign w_iss    = iss_valid && !flush_d && !w_stall;

  // Clear before set: a done and a new long issue to the same register never coincide.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_nxt  = r_err;
    if (lu_done) begin
      if (!r_busy[lu_rd]) w_err_nxt = 1'b1;
      w_busy_nxt[lu_rd] = 1'b0;
    end
    if (w_iss && iss_long && iss_we && (iss_rd != '0)) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= int'(NFWD); k++) begin
        r_v[k]   <= 1'b0;
        r_we[k]  <= 1'b0;
        r_rd[k]  <= '0;
        r_lat[k] <= '0;
      end
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int k = int'(NFWD); k >= 2; k--) begin
        r_v[k]   <= r_v[k-1];
        r_we[k]  <= r_we[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_lat[k] <= r_lat[k-1];
      end
      r_v[1]   <= w_iss && !iss_long;
      r_we[1]  <= w_iss && !iss_long && iss_we && (iss_rd != '0);
      r_rd[1]  <= iss_rd;
      r_lat[1] <= iss_lat;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign stall_f = w_stall && !rst;
  assign stall_d = w_stall && !rst;
  assign flush_e = w_stall && !rst;
  assign fwd1_d  = rst ? '0 : w_fwd[0];
  assign fwd2_d  = rst ? '0 : w_fwd[1];
  assign sb_busy = r_busy;
  assign sb_err  = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NFWD = 3;
  localparam int LW   = 2;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] rs1_d, rs2_d, iss_rd, lu_rd;
  logic use1_d, use2_d, iss_valid, iss_we, iss_long, flush_d, lu_ready, lu_done;
  logic [LW-1:0] iss_lat;
  logic stall_f, stall_d, flush_e, sb_err;
  logic [SW-1:0] fwd1_d, fwd2_d;
  logic [NREG-1:0] sb_busy;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .NFWD(NFWD), .LW(LW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use1_d(use1_d), .use2_d(use2_d),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .iss_long(iss_long), .flush_d(flush_d), .lu_ready(lu_ready), .lu_done(lu_done),
    .lu_rd(lu_rd), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd1_d(fwd1_d), .fwd2_d(fwd2_d), .sb_busy(sb_busy), .sb_err(sb_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    int            lat;
  } ent_t;

  ent_t            mq[$];   // mq[i] is the writer of age i+1
  logic [NREG-1:0] mbusy;
  logic            merr;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void src_eval(input logic [AW-1:0] rs, input logic u,
                                   output logic hz, output logic [SW-1:0] f);
    hz = 1'b0;
    f  = '0;
    if (!u || rs == '0) return;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].we && mq[i].rd == rs) begin
        if (i + 1 >= mq[i].lat) f = SW'(i + 1);
        else hz = 1'b1;
        return;
      end
    end
    hz = mbusy[rs];
  endfunction

  function automatic void model(output logic st, output logic [SW-1:0] f1,
                                output logic [SW-1:0] f2);
    logic h1, h2, hs;
    src_eval(rs1_d, use1_d, h1, f1);
    src_eval(rs2_d, use2_d, h2, f2);
    hs = (iss_long && !lu_ready) || (iss_we && iss_rd != '0 && mbusy[iss_rd]);
    st = iss_valid && !flush_d && (h1 || h2 || hs);
  endfunction

  task automatic model_reset();
    ent_t b;
    b.we = 1'b0; b.rd = '0; b.lat = 1;
    mq = {};
    for (int i = 0; i < NFWD; i++) mq.push_back(b);
    mbusy = '0;
    merr  = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        logic st, iss;
        logic [SW-1:0] f1, f2;
        ent_t e;
        model(st, f1, f2);
        iss  = iss_valid && !flush_d && !st;
        e.we = iss && !iss_long && iss_we && iss_rd != '0;
        e.rd = iss_rd;
        e.lat = (iss_lat == '0) ? 1 : int'(iss_lat);
        if (lu_done) begin
          if (!mbusy[lu_rd]) merr = 1'b1;
          mbusy[lu_rd] = 1'b0;
        end
        if (iss && iss_long && iss_we && iss_rd != '0) mbusy[iss_rd] = 1'b1;
        mq.push_front(e);
        void'(mq.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_stall_f", stall_f, 0);
        chk("rst_fwd1", fwd1_d, 0);
        chk("rst_fwd2", fwd2_d, 0);
        chk("rst_busy", sb_busy, 0);
      end else begin
        logic st;
        logic [SW-1:0] f1, f2;
        model(st, f1, f2);
        chk("m_stall_f", stall_f, st);
        chk("m_stall_d", stall_d, st);
        chk("m_flush_e", flush_e, st);
        chk("m_fwd1", fwd1_d, f1);
        chk("m_fwd2", fwd2_d, f2);
        chk("m_busy", sb_busy, mbusy);
        chk("m_err", sb_err, merr);
      end
    end
  end

  task automatic idle();
    rs1_d = '0; rs2_d = '0; use1_d = 0; use2_d = 0; iss_valid = 0; iss_we = 0;
    iss_rd = '0; iss_lat = '0; iss_long = 0; flush_d = 0; lu_ready = 1; lu_done = 0;
    lu_rd = '0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] rd, input logic [LW-1:0] lat, input logic lng);
    idle();
    iss_valid = 1; iss_we = 1; iss_rd = rd; iss_lat = lat; iss_long = lng;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 chk("reset_busy", sb_busy, 0);
    chk("reset_err", sb_err, 0);
    chk("reset_stall", stall_d, 0);
    go();

    // Back-to-back ALU forwarding at ages 1, 2, 3
    wr(5'd5, 2'd1, 0);
    #1 chk("alu_issue_stall", stall_d, 0);
    go();
    wr(5'd10, 2'd1, 0); rs1_d = 5'd5; use1_d = 1;
    #1 chk("alu_fwd_age1", fwd1_d, 1);
    chk("alu_age1_stall", stall_f, 0);
    go();
    idle(); iss_valid = 1; rs2_d = 5'd5; use2_d = 1;
    #1 chk("alu_fwd_age2", fwd2_d, 2);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd5; use1_d = 1;
    #1 chk("alu_fwd_age3", fwd1_d, 3);
    go();
    idle(); repeat (3) go();

    // Load-use: one stall then age-2 bypass
    wr(5'd6, 2'd2, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd6; use1_d = 1;
    #1 chk("ld_use_stall_f", stall_f, 1);
    chk("ld_use_stall_d", stall_d, 1);
    chk("ld_use_flush_e", flush_e, 1);
    go();
    #1 chk("ld_use_after_stall", stall_d, 0);
    chk("ld_use_fwd2", fwd1_d, 2);
    go();
    idle(); repeat (3) go();

    // Long op and a dependent reader
    wr(5'd7, 2'd1, 1);
    #1 chk("div_issue_stall", stall_d, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd7; use1_d = 1;
    #1 chk("div_raw_stall", stall_d, 1);
    chk("div_busy7", sb_busy[7], 1);
    go(); go();
    lu_done = 1; lu_rd = 5'd7;
    #1 chk("div_done_cycle_stall", stall_d, 1);
    go();
    lu_done = 0;
    #1 chk("div_post_stall", stall_d, 0);
    chk("div_post_fwd", fwd1_d, 0);
    chk("div_busy7_clear", sb_busy[7], 0);
    go();
    idle(); repeat (3) go();

    // WAW against in-flight long op, then back-pressure
    wr(5'd8, 2'd1, 1);
    go();
    wr(5'd8, 2'd1, 0);
    #1 chk("waw_stall", stall_d, 1);
    go();
    lu_done = 1; lu_rd = 5'd8;
    #1 chk("waw_done_cycle", stall_d, 1);
    go();
    lu_done = 0;
    #1 chk("waw_released", stall_d, 0);
    go();
    wr(5'd11, 2'd1, 1); lu_ready = 0;
    #1 chk("lu_backpressure", stall_d, 1);
    go();
    lu_ready = 1;
    #1 chk("lu_ready_go", stall_d, 0);
    go();
    idle(); lu_done = 1; lu_rd = 5'd11;
    go();
    idle();
    #1 chk("waw_no_err", sb_err, 0);
    chk("waw_busy_empty", sb_busy, 0);
    repeat (3) go();

    // x0, unused sources, flush override, lat=0
    wr(5'd0, 2'd2, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd0; use1_d = 1; rs2_d = 5'd0; use2_d = 1;
    #1 chk("x0_stall", stall_d, 0);
    chk("x0_fwd", fwd1_d, 0);
    go();
    wr(5'd12, 2'd2, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd12; rs2_d = 5'd12;
    #1 chk("unused_stall", stall_d, 0);
    chk("unused_fwd", fwd2_d, 0);
    go();
    wr(5'd13, 2'd2, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd13; use1_d = 1; flush_d = 1;
    #1 chk("flush_no_stall", stall_f, 0);
    chk("flush_fwd", fwd1_d, 0);
    go();
    wr(5'd16, 2'd0, 0);
    go();
    idle(); iss_valid = 1; rs2_d = 5'd16; use2_d = 1;
    #1 chk("lat0_fwd", fwd2_d, 1);
    chk("lat0_stall", stall_d, 0);
    go();
    idle(); repeat (3) go();

    // Reset mid-stall with busy[9] and a full pipe
    wr(5'd9, 2'd1, 1);
    go();
    wr(5'd14, 2'd1, 0);
    go();
    wr(5'd15, 2'd1, 0);
    go();
    idle(); iss_valid = 1; rs1_d = 5'd9; use1_d = 1;
    #1 chk("pre_rst_stall", stall_d, 1);
    chk("pre_rst_busy9", sb_busy[9], 1);
    rst = 1;
    #1 chk("rst_mid_stall_f", stall_f, 0);
    chk("rst_mid_flush_e", flush_e, 0);
    chk("rst_mid_busy", sb_busy, 0);
    go();
    idle(); rst = 0;
    #1 chk("post_rst_busy", sb_busy, 0);
    chk("post_rst_stall", stall_d, 0);
    go();
    lu_done = 1; lu_rd = 5'd3;
    go();
    idle();
    #1 chk("spurious_done_err", sb_err, 1);
    go(); go();
    #1 chk("err_sticky", sb_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
